// File: rtl/mailbox_obi_reader_if.sv
// OBI request/response channel between the mailbox reader (master) and the mailbox slave.
// Bus signals only; the stream side and status stay plain ports on the reader.
interface mailbox_obi_reader_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req;
  logic                  gnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mailbox_obi_reader.sv
// OBI reader draining a mailbox into a FIFO stream; word visible 1 cycle after rvalid, >=2 cycles/word.
// Requests stop when the FIFO (plus the in-flight word) would be full; consumer stalls via ready_i.
module mailbox_obi_reader #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] MBOX_ADDR  = '0,
  parameter int unsigned           FIFO_DEPTH = 4,
  localparam int unsigned          CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  flush_i,
  mailbox_obi_reader_if.master  obi,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [CNT_W-1:0]      count_o,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [15:0]           word_cnt_o
);

  localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d, wr_addr;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  err_q, err_d;
  logic [15:0]           word_cnt_q, word_cnt_d;
  logic                  push, pop;

  assign push = (state_q == ST_WAIT) && obi.rvalid;
  assign pop  = valid_o && ready_i;

  // A flush restarts the FIFO at slot 0, so a same-cycle push lands there.
  assign wr_addr = flush_i ? '0 : wptr_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = push ? PTR_W'(1) : '0;
      count_d = push ? CNT_W'(1) : '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q | (obi.rvalid && (state_q != ST_WAIT));
    word_cnt_d = push ? word_cnt_q + 16'd1 : word_cnt_q;
    case (state_q)
      ST_IDLE: if (enable_i && (count_q < DEPTH_C)) state_d = ST_REQ;
      ST_REQ:  if (obi.gnt) state_d = ST_WAIT;
      // Post-update occupancy decides chaining, keeping one slot for the in-flight word.
      ST_WAIT: if (push) state_d = (enable_i && (count_d < DEPTH_C)) ? ST_REQ : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_addr] <= obi.rdata;
  end

  assign obi.req   = (state_q == ST_REQ);
  assign obi.addr  = MBOX_ADDR;
  assign obi.we    = 1'b0;
  assign obi.be    = 4'hF;
  assign obi.wdata = '0;

  assign valid_o    = (count_q != '0);
  assign data_o     = valid_o ? mem_q[rptr_q] : '0;
  assign count_o    = count_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign err_o      = err_q;
  assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_mailbox_obi_reader.sv
// Directed bench for mailbox_obi_reader: a per-cycle vector table plus hand sequences
// for backpressure, streaming order, flush, async reset and counter wrap.
module tb_mailbox_obi_reader;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        enable_i, flush_i, ready_i;
  logic [31:0] data_o;
  logic        valid_o, busy_o, err_o;
  logic [2:0]  count_o;
  logic [15:0] word_cnt_o;

  int checks   = 0;
  int failures = 0;

  mailbox_obi_reader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) obi_if ();

  mailbox_obi_reader #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MBOX_ADDR(32'h0), .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .flush_i(flush_i),
    .obi(obi_if), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .count_o(count_o), .busy_o(busy_o), .err_o(err_o), .word_cnt_o(word_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        req, busy, vld;
    logic [31:0] dat;
    logic [2:0]  cnt;
    logic        err;
    logic [15:0] wc;
  } outs_t;

  typedef struct packed {
    logic        en, fl, gnt, rv;
    logic [31:0] rdata;
    logic        rdy;
    outs_t       exp;
  } vec_t;

  function automatic vec_t mkv(logic en, logic fl, logic gnt, logic rv, logic [31:0] rd, logic rdy,
                               logic req, logic busy, logic vld, logic [31:0] dat,
                               logic [2:0] cnt, logic err, logic [15:0] wc);
    vec_t v;
    v.en = en; v.fl = fl; v.gnt = gnt; v.rv = rv; v.rdata = rd; v.rdy = rdy;
    v.exp.req = req; v.exp.busy = busy; v.exp.vld = vld; v.exp.dat = dat;
    v.exp.cnt = cnt; v.exp.err = err; v.exp.wc = wc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    enable_i = 0; flush_i = 0; ready_i = 0;
    obi_if.gnt = 0; obi_if.rvalid = 0; obi_if.rdata = '0;
    rst_ni = 0;
    #3;
    rst_ni = 1;
  endtask

  logic [31:0] nxt;

  // Slave that grants immediately and answers in the first WAIT cycle.
  task automatic auto_step(input bit rv_en, output bit granted, output bit pushed);
    obi_if.gnt    = obi_if.req;
    obi_if.rvalid = rv_en && busy_o && !obi_if.req;
    obi_if.rdata  = nxt;
    granted = obi_if.req;
    pushed  = obi_if.rvalid;
    if (pushed) nxt = nxt + 1;
    tick();
  endtask

  vec_t  vecs [11];
  outs_t act;
  int    grants, exp_out, sim_seen;
  bit    g, p, req_ok, sim, found;
  logic [2:0] prev_cnt;

  initial begin
    vecs[0]  = mkv(1,0,0,0,32'h0,        0, 0,0,0,32'h0,        3'd0,0,16'd0);
    vecs[1]  = mkv(1,0,1,0,32'h0,        0, 1,1,0,32'h0,        3'd0,0,16'd0);
    vecs[2]  = mkv(1,0,0,0,32'h0,        0, 0,1,0,32'h0,        3'd0,0,16'd0);
    vecs[3]  = mkv(1,0,0,1,32'hA5A50001, 0, 0,1,0,32'h0,        3'd0,0,16'd0);
    vecs[4]  = mkv(0,0,0,0,32'h0,        0, 1,1,1,32'hA5A50001, 3'd1,0,16'd1);
    vecs[5]  = mkv(0,0,1,0,32'h0,        0, 1,1,1,32'hA5A50001, 3'd1,0,16'd1);
    vecs[6]  = mkv(0,0,0,1,32'h2,        0, 0,1,1,32'hA5A50001, 3'd1,0,16'd1);
    vecs[7]  = mkv(0,0,0,0,32'h0,        1, 0,0,1,32'hA5A50001, 3'd2,0,16'd2);
    vecs[8]  = mkv(0,0,0,1,32'h0,        0, 0,0,1,32'h2,        3'd1,0,16'd2);
    vecs[9]  = mkv(0,0,0,0,32'h0,        1, 0,0,1,32'h2,        3'd1,1,16'd2);
    vecs[10] = mkv(0,0,0,0,32'h0,        0, 0,0,0,32'h0,        3'd0,1,16'd2);

    do_reset();
    chk("const_bus", {obi_if.addr, obi_if.we, obi_if.be, obi_if.wdata[26:0]},
        {32'h0, 1'b0, 4'hF, 27'h0});
    for (int i = 0; i < 11; i++) begin
      enable_i = vecs[i].en; flush_i = vecs[i].fl; ready_i = vecs[i].rdy;
      obi_if.gnt = vecs[i].gnt; obi_if.rvalid = vecs[i].rv; obi_if.rdata = vecs[i].rdata;
      act = {obi_if.req, busy_o, valid_o, data_o, count_o, err_o, word_cnt_o};
      chk($sformatf("vec%0d", i), 64'(act), 64'(vecs[i].exp));
      tick();
    end

    // Grant withheld for 10 cycles, enable dropped partway: request must not retract.
    do_reset();
    enable_i = 1;
    tick();
    req_ok = 1;
    for (int i = 0; i < 10; i++) begin
      enable_i = (i < 2);
      obi_if.gnt = 0;
      if (!obi_if.req) req_ok = 0;
      tick();
    end
    chk("req_held", 64'(req_ok), 64'd1);
    obi_if.gnt = 1;
    tick();
    obi_if.gnt = 0;
    chk("wait_after_gnt", 64'(busy_o && !obi_if.req), 64'd1);
    obi_if.rvalid = 1; obi_if.rdata = 32'hBEEF;
    tick();
    obi_if.rvalid = 0;
    chk("held_one_word", {count_o, busy_o, data_o}, {3'd1, 1'b0, 32'hBEEF});
    repeat (3) tick();
    chk("held_no_rereq", {obi_if.req, count_o, word_cnt_o}, {1'b0, 3'd1, 16'd1});

    // Consumer stalled: fill exactly to depth, then one pop allows exactly one more read.
    do_reset();
    enable_i = 1; nxt = 1; grants = 0;
    repeat (30) begin auto_step(1, g, p); if (g) grants++; end
    chk("fill_grants", 64'(grants), 64'd4);
    chk("fill_state", {count_o, obi_if.req, busy_o, data_o}, {3'd4, 1'b0, 1'b0, 32'd1});
    obi_if.gnt = 0; obi_if.rvalid = 0; ready_i = 1;
    tick();
    ready_i = 0;
    chk("pop_head", {count_o, data_o}, {3'd3, 32'd2});
    grants = 0;
    repeat (10) begin auto_step(1, g, p); if (g) grants++; end
    chk("refill_grants", 64'(grants), 64'd1);
    chk("refill_count", 64'(count_o), 64'd4);

    // Streaming with ready high: in-order delivery, count steady on push+pop.
    do_reset();
    enable_i = 1; nxt = 1; exp_out = 1; sim_seen = 0; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (count_o == 3'd2) found = 1; else auto_step(1, g, p);
    end
    chk("stream_prefill", 64'(found), 64'd1);
    ready_i = 1;
    for (int i = 0; i < 40; i++) begin
      if (i == 30) enable_i = 0;
      prev_cnt = count_o;
      if (valid_o) begin chk("stream_order", 64'(data_o), 64'(exp_out)); exp_out++; end
      sim = valid_o && busy_o && !obi_if.req;
      auto_step(1, g, p);
      if (sim) begin sim_seen++; chk("push_pop_count", 64'(count_o), 64'(prev_cnt)); end
    end
    chk("push_pop_seen", 64'(sim_seen > 0), 64'd1);
    chk("stream_no_loss", {32'(exp_out), count_o, busy_o}, {nxt, 3'd0, 1'b0});

    // Flush while a word is in flight with three buffered.
    do_reset();
    enable_i = 1; nxt = 32'h100; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (count_o == 3'd3 && busy_o && !obi_if.req) found = 1; else auto_step(1, g, p);
    end
    chk("flush_setup", 64'(found), 64'd1);
    obi_if.gnt = 0; obi_if.rvalid = 0; flush_i = 1;
    tick();
    flush_i = 0;
    chk("flush_clear", {count_o, valid_o, busy_o}, {3'd0, 1'b0, 1'b1});
    enable_i = 0; obi_if.rvalid = 1; obi_if.rdata = 32'hF00D0000;
    tick();
    obi_if.rvalid = 0;
    chk("flush_inflight", {count_o, valid_o, data_o}, {3'd1, 1'b1, 32'hF00D0000});
    enable_i = 1;
    tick();
    enable_i = 0; obi_if.gnt = 1;
    tick();
    obi_if.gnt = 0; obi_if.rvalid = 1; obi_if.rdata = 32'hCAFE0001; flush_i = 1;
    tick();
    obi_if.rvalid = 0; flush_i = 0;
    chk("flush_with_push", {count_o, data_o, busy_o}, {3'd1, 32'hCAFE0001, 1'b0});

    // Async reset in WAIT drops the transaction; the late response is an error.
    do_reset();
    chk("err_cleared", 64'(err_o), 64'd0);
    enable_i = 1;
    tick();
    obi_if.gnt = 1;
    tick();
    obi_if.gnt = 0; enable_i = 0;
    chk("busy_in_wait", {busy_o, obi_if.req}, {1'b1, 1'b0});
    rst_ni = 0;
    #1;
    chk("async_reset", 64'(busy_o), 64'd0);
    rst_ni = 1;
    obi_if.rvalid = 1; obi_if.rdata = 32'h1234;
    tick();
    obi_if.rvalid = 0;
    chk("late_rvalid", {err_o, count_o, word_cnt_o}, {1'b1, 3'd0, 16'd0});

    // Word counter wrap.
    do_reset();
    force dut.word_cnt_q = 16'hFFFF;
    tick();
    tick();
    release dut.word_cnt_q;
    chk("wc_preset", 64'(word_cnt_o), 64'hFFFF);
    enable_i = 1;
    tick();
    enable_i = 0; obi_if.gnt = 1;
    tick();
    obi_if.gnt = 0; obi_if.rvalid = 1; obi_if.rdata = 32'h77;
    tick();
    obi_if.rvalid = 0;
    chk("wc_wrap", {word_cnt_o, count_o}, {16'h0000, 3'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
